// File: rtl/fetch_stage.sv
// fetch_stage: RV32I fetch with PC, ROM and FE latch; FE_PERF_CNT_EN adds stall/flush counters
module fetch_stage #(
  parameter int              DBITS          = 32,
  parameter int              INSTBITS       = 32,
  parameter int              IMEMADDRBITS   = 10,
  parameter logic [DBITS-1:0] START_PC      = '0,
  parameter string           IMEM_INIT_FILE = "test.mem"
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          from_DE_to_FE,
  input  logic [DBITS:0]                from_AGEX_to_FE,
  output logic [INSTBITS+3*DBITS:0]     FE_latch_out
`ifdef FE_PERF_CNT_EN
  ,
  output logic [31:0]                   stall_cnt_FE,
  output logic [31:0]                   flush_cnt_FE
`endif
);
  logic [INSTBITS-1:0]         r_imem [0:2**IMEMADDRBITS-1];
  logic [DBITS-1:0]            r_pc;
  logic [DBITS-1:0]            r_count;
  logic [INSTBITS+3*DBITS:0]   r_latch;
  logic                        w_stall;
  logic                        w_redirect;
  logic [DBITS-1:0]            w_target;
  logic [DBITS-1:0]            w_pcplus;
  logic [INSTBITS-1:0]         w_inst;

  assign w_stall      = from_DE_to_FE;
  assign w_redirect   = from_AGEX_to_FE[DBITS];
  assign w_target     = from_AGEX_to_FE[DBITS-1:0] & ~DBITS'(3);
  assign w_pcplus     = r_pc + DBITS'(4);
  assign w_inst       = r_imem[r_pc[IMEMADDRBITS+1:2]];
  assign FE_latch_out = r_latch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= START_PC;
      r_count <= '0;
      r_latch <= '0;
    end else if (w_redirect) begin
      r_pc    <= w_target;
      r_latch <= '0;
    end else if (!w_stall) begin
      r_latch <= {1'b1, w_inst, r_pc, w_pcplus, r_count};
      r_pc    <= w_pcplus;
      r_count <= r_count + DBITS'(1);
    end
  end

`ifdef FE_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  assign stall_cnt_FE = r_stall_cnt;
  assign flush_cnt_FE = r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 32'(w_stall && !w_redirect && !(&r_stall_cnt));
      r_flush_cnt <= r_flush_cnt + 32'(w_redirect && !(&r_flush_cnt));
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven check of fetch, stall, redirect, wrap and reset behaviour
module tb_fetch_stage;
  logic         clk = 0;
  logic         reset = 1;
  logic         stall = 0;
  logic         redirect = 0;
  logic [31:0]  target = 0;
  logic [128:0] latch;
`ifdef FE_PERF_CNT_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  flush_cnt;
`endif
  int n_checks = 0;
  int n_errors = 0;

  fetch_stage #(.IMEM_INIT_FILE("")) dut (
    .clk             (clk),
    .reset           (reset),
    .from_DE_to_FE   (stall),
    .from_AGEX_to_FE ({redirect, target}),
    .FE_latch_out    (latch)
`ifdef FE_PERF_CNT_EN
    ,
    .stall_cnt_FE    (stall_cnt),
    .flush_cnt_FE    (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] tgt;
    logic        v;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pcp;
    logic [31:0] cnt;
    logic [31:0] pcfe;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [31:0] rom(int i);
    return i == 0 ? 32'h0010_0093 : i == 1 ? 32'h0020_0113 : i == 2 ? 32'h0030_0193 : 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic chk(string name, logic [128:0] act, logic [128:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(logic st, logic rd, logic [31:0] tgt, logic rst);
    stall = st;
    redirect = rd;
    target = tgt;
    reset = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dut.r_imem[i] = rom(i);
    vecs[0]  = '{0, 0, 32'h0,        1, rom(0),    32'h0,        32'h4,    32'd0, 32'h4};
    vecs[1]  = '{0, 0, 32'h0,        1, rom(1),    32'h4,        32'h8,    32'd1, 32'h8};
    vecs[2]  = '{1, 0, 32'h0,        1, rom(1),    32'h4,        32'h8,    32'd1, 32'h8};
    vecs[3]  = '{1, 0, 32'h0,        1, rom(1),    32'h4,        32'h8,    32'd1, 32'h8};
    vecs[4]  = '{1, 0, 32'h0,        1, rom(1),    32'h4,        32'h8,    32'd1, 32'h8};
    vecs[5]  = '{0, 0, 32'h0,        1, rom(2),    32'h8,        32'hC,    32'd2, 32'hC};
    vecs[6]  = '{0, 1, 32'h40,       0, 32'h0,     32'h0,        32'h0,    32'd0, 32'h40};
    vecs[7]  = '{0, 0, 32'h0,        1, rom(16),   32'h40,       32'h44,   32'd3, 32'h44};
    vecs[8]  = '{1, 1, 32'h13,       0, 32'h0,     32'h0,        32'h0,    32'd0, 32'h10};
    vecs[9]  = '{0, 0, 32'h0,        1, rom(4),    32'h10,       32'h14,   32'd4, 32'h14};
    vecs[10] = '{0, 1, 32'hFFC,      0, 32'h0,     32'h0,        32'h0,    32'd0, 32'hFFC};
    vecs[11] = '{0, 0, 32'h0,        1, rom(1023), 32'hFFC,      32'h1000, 32'd5, 32'h1000};
    vecs[12] = '{0, 0, 32'h0,        1, rom(0),    32'h1000,     32'h1004, 32'd6, 32'h1004};
    vecs[13] = '{0, 1, 32'hFFFFFFFC, 0, 32'h0,     32'h0,        32'h0,    32'd0, 32'hFFFFFFFC};
    vecs[14] = '{0, 0, 32'h0,        1, rom(1023), 32'hFFFFFFFC, 32'h0,    32'd7, 32'h0};
    vecs[15] = '{0, 0, 32'h0,        1, rom(0),    32'h0,        32'h4,    32'd8, 32'h4};

    step(0, 0, 0, 1);
    chk("reset_latch", latch, '0);
    chk("reset_pc", 129'(dut.r_pc), 129'h0);
`ifdef FE_PERF_CNT_EN
    chk("reset_stall_cnt", 129'(stall_cnt), 129'h0);
    chk("reset_flush_cnt", 129'(flush_cnt), 129'h0);
`endif

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].st, vecs[i].rd, vecs[i].tgt, 0);
      chk($sformatf("vec%0d_latch", i), latch,
          {vecs[i].v, vecs[i].inst, vecs[i].pc, vecs[i].pcp, vecs[i].cnt});
      chk($sformatf("vec%0d_pc_fe", i), 129'(dut.r_pc), 129'(vecs[i].pcfe));
    end
`ifdef FE_PERF_CNT_EN
    chk("stall_cnt", 129'(stall_cnt), 129'd3);
    chk("flush_cnt", 129'(flush_cnt), 129'd4);
`endif

    step(0, 1, 32'h20, 0);
    step(0, 0, 0, 0);
    chk("pre_stall_latch", latch, {1'b1, rom(8), 32'h20, 32'h24, 32'd9});
    step(1, 0, 0, 0);
    chk("stall_pc_fe", 129'(dut.r_pc), 129'h24);
`ifdef FE_PERF_CNT_EN
    chk("stall_cnt2", 129'(stall_cnt), 129'd4);
    chk("flush_cnt2", 129'(flush_cnt), 129'd5);
`endif
    step(1, 1, 32'h80, 1);
    chk("mid_reset_latch", latch, '0);
    chk("mid_reset_pc", 129'(dut.r_pc), 129'h0);
`ifdef FE_PERF_CNT_EN
    chk("mid_reset_stall_cnt", 129'(stall_cnt), 129'h0);
    chk("mid_reset_flush_cnt", 129'(flush_cnt), 129'h0);
`endif
    step(0, 0, 0, 0);
    chk("resume0", latch, {1'b1, rom(0), 32'h0, 32'h4, 32'd0});
    step(0, 0, 0, 0);
    chk("resume1", latch, {1'b1, rom(1), 32'h4, 32'h8, 32'd1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
